// File: rtl/whack_detector.sv
// -----------------------------------------------------------------------------
// whack_detector
//   Whack-a-mole button evaluator. It synchronizes and debounces nine raw player
//   buttons and turns each accepted press into a one-cycle hit or miss pulse.
//   A hit happens when exactly one button is pressed and its LED is lit; it
//   bumps the score and asks the light driver to turn that LED off.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles before a button change is
//                     accepted (1 .. 2^20-1)
//   SCORE_W         : score register width
//
// Ports
//   CLOCK_50  in   sole clock, rising edge
//   reset     in   asynchronous active-high reset
//   buttons   in   [8:0] raw buttons, active-high, asynchronous
//   lights    in   [8:0] current LED vector from the light driver
//   clear_ack in   light driver confirms the lit LED is off
//   clear_req out  request to turn off the whacked LED (high throughout CLEAR)
//   hit       out  one-cycle pulse on a valid whack
//   miss      out  one-cycle pulse on an invalid whack
//   hit_index out  [3:0] button position of the last hit
//   score     out  [SCORE_W-1:0] saturating hit count
//
// Build option
//   WAM_MISS_PENALTY_EN : when defined, each miss decrements the score,
//                         saturating at zero.
// -----------------------------------------------------------------------------
module whack_detector #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCORE_W         = 16
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [8:0]         buttons,
  input  logic [8:0]         lights,
  input  logic               clear_ack,
  output logic               clear_req,
  output logic               hit,
  output logic               miss,
  output logic [3:0]         hit_index,
  output logic [SCORE_W-1:0] score
);

  localparam logic [19:0] DEB_MAX  = 20'(DEBOUNCE_CYCLES);
  // The debounced vector loads on the edge where the counter steps onto DEB_MAX.
  localparam logic [19:0] DEB_LOAD = 20'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    CLEAR   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  logic [8:0]         sync1_r;
  logic [8:0]         sync2_r;
  logic [8:0]         sync_prev_r;
  logic [19:0]        cnt_r;
  logic [8:0]         deb_r;
  logic [8:0]         press_r;
  logic [8:0]         cap_press_r;
  logic [8:0]         cap_lights_r;
  state_t             state_r;
  logic               clear_req_r;
  logic               hit_r;
  logic               miss_r;
  logic [3:0]         hit_index_r;
  logic [SCORE_W-1:0] score_r;

  logic               stable_s;
  logic [8:0]         deb_next_s;

  // Position of the highest set bit; callers only use it on one-hot vectors.
  function automatic logic [3:0] bit_index(input logic [8:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

  // Next debounced value: accept the synchronized vector once it has been stable long enough.
  always_comb begin
    stable_s   = (sync2_r == sync_prev_r);
    deb_next_s = deb_r;
    if (stable_s && (cnt_r >= DEB_LOAD)) begin
      deb_next_s = sync2_r;
    end else begin
      deb_next_s = deb_r;
    end
  end

  // Two-flop synchronizer, shared debounce counter, debounced vector and press-edge register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_r     <= 9'd0;
      sync2_r     <= 9'd0;
      sync_prev_r <= 9'd0;
      cnt_r       <= 20'd0;
      deb_r       <= 9'd0;
      press_r     <= 9'd0;
    end else begin
      sync1_r     <= buttons;
      sync2_r     <= sync1_r;
      sync_prev_r <= sync2_r;
      if (!stable_s) begin
        cnt_r <= 20'd0;
      end else if (cnt_r < DEB_MAX) begin
        cnt_r <= cnt_r + 20'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      deb_r   <= deb_next_s;
      // Registered off the next debounced value so IDLE sees the press one cycle after it is accepted.
      press_r <= deb_next_s & ~deb_r;
    end
  end

  // Game FSM with registered hit/miss/clear_req, hit index and score.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cap_press_r  <= 9'd0;
      cap_lights_r <= 9'd0;
      clear_req_r  <= 1'b0;
      hit_r        <= 1'b0;
      miss_r       <= 1'b0;
      hit_index_r  <= 4'd0;
      score_r      <= {SCORE_W{1'b0}};
    end else begin
      hit_r  <= 1'b0;
      miss_r <= 1'b0;
      case (state_r)
        IDLE: begin
          clear_req_r <= 1'b0;
          if (press_r != 9'd0) begin
            cap_press_r  <= press_r;
            cap_lights_r <= lights;
            state_r      <= EVAL;
          end else begin
            state_r <= IDLE;
          end
        end
        EVAL: begin
          if (is_onehot(cap_press_r) && ((cap_press_r & cap_lights_r) != 9'd0)) begin
            hit_r       <= 1'b1;
            hit_index_r <= bit_index(cap_press_r);
            if (score_r != {SCORE_W{1'b1}}) begin
              score_r <= score_r + SCORE_W'(1);
            end else begin
              score_r <= score_r;
            end
            clear_req_r <= 1'b1;
            state_r     <= CLEAR;
          end else begin
            miss_r <= 1'b1;
`ifdef WAM_MISS_PENALTY_EN
            if (score_r != {SCORE_W{1'b0}}) begin
              score_r <= score_r - SCORE_W'(1);
            end else begin
              score_r <= score_r;
            end
`endif
            clear_req_r <= 1'b0;
            state_r     <= RELEASE;
          end
        end
        CLEAR: begin
          if (clear_ack) begin
            clear_req_r <= 1'b0;
            state_r     <= RELEASE;
          end else begin
            clear_req_r <= 1'b1;
            state_r     <= CLEAR;
          end
        end
        RELEASE: begin
          clear_req_r <= 1'b0;
          // Wait for every button to be released so one press cannot score twice.
          if (deb_r == 9'd0) begin
            state_r <= IDLE;
          end else begin
            state_r <= RELEASE;
          end
        end
        default: begin
          clear_req_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign clear_req = clear_req_r;
  assign hit       = hit_r;
  assign miss      = miss_r;
  assign hit_index = hit_index_r;
  assign score     = score_r;

endmodule

// File: doc/whack_detector.md
WHACK_DETECTOR -- requirements
Module: whack_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, sets consecutive stable cycles before a button change is accepted (10 ms at 50 MHz); legal range 1 to 2^20-1.
REQ-002 Parameter SCORE_W, default 16, sets score register width.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 buttons  input  9  raw player buttons, active-high pressed, asynchronous to CLOCK_50.
REQ-006 lights  input  9  current LED vector from the light driver, synchronous to CLOCK_50.
REQ-007 clear_ack  input  1  light driver acknowledges that the lit LED was turned off.
REQ-008 clear_req  output  1  request to the light driver to turn off the whacked LED.
REQ-009 hit  output  1  single-cycle pulse on a valid whack.
REQ-010 miss  output  1  single-cycle pulse on an invalid whack.
REQ-011 hit_index  output  4  index 0-8 of the button that scored the last hit.
REQ-012 score  output  SCORE_W  running hit count.

Function
REQ-013 Each buttons bit SHALL pass through a two-flop synchronizer before any other use.
REQ-014 A shared 20-bit debounce counter SHALL reset to 0 whenever the synchronized vector differs from its previous-cycle value, otherwise increment, saturating at DEBOUNCE_CYCLES.
REQ-015 The debounced vector SHALL take the synchronized value in the cycle the counter reaches DEBOUNCE_CYCLES.
REQ-016 A press event SHALL be the set of debounced bits that rose in that cycle (rising-edge vector, registered).
REQ-017 FSM states: IDLE, EVAL, CLEAR, RELEASE; reset state IDLE.
REQ-018 IDLE: a nonzero press event SHALL capture the press vector and the lights vector and move to EVAL; otherwise stay.
REQ-019 EVAL (exactly one cycle): press vector one-hot AND that lights bit set -> hit, go CLEAR; any other case (zero lit match, multiple simultaneous presses) -> miss, go RELEASE.
REQ-020 hit and miss SHALL be registered, high for exactly the one cycle following EVAL, never both.
REQ-021 On hit, hit_index SHALL load the pressed bit position and hold until the next hit.
REQ-022 On hit, score SHALL increment by 1, saturating at all ones (no wrap).
REQ-023 CLEAR: clear_req SHALL be high for every cycle in CLEAR; on clear_ack high, go RELEASE (clear_req low in the next cycle).
REQ-024 clear_ack while not in CLEAR SHALL be ignored.
REQ-025 RELEASE: stay until the debounced vector is all zero, then go IDLE.
REQ-026 Press events arising in EVAL, CLEAR or RELEASE SHALL be discarded (no hit/miss, no score change).
REQ-027 Latency: hit/miss SHALL assert exactly 2 cycles after the debounced bit rises.

Reset
REQ-028 While reset is high: clear_req=0, hit=0, miss=0, hit_index=0, score=0, FSM=IDLE, synchronizer, debounced vector and debounce counter all 0, asynchronously.
REQ-029 Reset asserted mid-operation (e.g. in CLEAR with clear_req high) SHALL drop clear_req immediately, with no pending hit/miss emitted after release.
REQ-030 After reset deassertion, a button already held SHALL register as a press only after full synchronization and debounce.

Configuration
REQ-031 Macro WAM_MISS_PENALTY_EN: when defined, each miss SHALL decrement score by 1, saturating at 0; when undefined, miss SHALL leave score unchanged.

Verification (DEBOUNCE_CYCLES=4, SCORE_W=4)
REQ-032 lights=9'h010, clean press of buttons bit 4 -> one hit pulse, hit_index=4, score 0->1, clear_req high until clear_ack, then RELEASE until button released.
REQ-033 lights=9'h001, press bit 3 -> one miss pulse, score unchanged (macro undefined) or stays 0 (macro defined, saturation); clear_req never asserted.
REQ-034 Bit 2 bouncing with pulses shorter than 4 cycles, then stable high -> exactly one evaluation after 4 stable cycles; no event during bounce.
REQ-035 Bits 1 and 5 rise in the same synchronized cycle with lights=9'h002 -> miss, no hit.
REQ-036 16 consecutive valid hits -> score saturates at 4'hF, no wrap; with macro defined, a later miss gives 4'hE.
REQ-037 Reset pulsed while in CLEAR -> clear_req low within the reset cycle, all outputs 0, next valid press scores normally.
